// File: rtl/sum_ascii_tx.sv
// rtl/sum_ascii_tx.sv - binary result word to ASCII decimal character stream
//
// Purpose:
//   Accepts an unsigned binary word and emits its decimal representation as ASCII
//   characters, one byte per handshake, most-significant digit first. Leading zeros
//   are suppressed (value 0 prints "0"), and an EOL byte follows the last digit.
//   The conversion is a sequential double-dabble, one input bit per clock.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_value is presented
//   in_ready   out  1      block accepts a value this cycle (IDLE only)
//   in_value   in   WIDTH  unsigned binary value to print
//   out_valid  out  1      out_data holds a character
//   out_ready  in   1      sink accepts out_data this cycle
//   out_data   out  8      ASCII character
//   busy       out  1      high from accept until the EOL byte is taken

module sum_ascii_tx #(
  parameter int         WIDTH = 6,
  parameter logic [7:0] EOL   = 8'h0A
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_value,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy
);

  // Decimal digits needed for the largest WIDTH-bit value.
  localparam int NDIG = (WIDTH <= 3) ? 1 : (WIDTH <= 6) ? 2 : (WIDTH <= 9) ? 3 : 4;
  localparam int BW   = NDIG * 4;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW   = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_SEND,
    S_EOLS
  } state_t;

  state_t           r_state;
  state_t           w_state_next;

  logic [WIDTH-1:0] r_shift;
  logic [BW-1:0]    r_bcd;
  logic [CW-1:0]    r_cnt;
  logic [IW-1:0]    r_dig_idx;
  logic [7:0]       r_out_data;
  logic             r_out_valid;

  logic             w_xfer;
  logic             w_conv_last;
  logic [BW-1:0]    w_bcd_adj;
  logic [BW-1:0]    w_bcd_shift;
  logic [IW-1:0]    w_first_idx;
  logic [3:0]       w_first_digit;
  logic [3:0]       w_next_digit;

  // Select BCD digit number idx (0 = units).
  function automatic logic [3:0] f_nibble(input logic [BW-1:0] bcd, input logic [IW-1:0] idx);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (IW'(i) == idx) n = bcd[i*4 +: 4];
    end
    return n;
  endfunction

  assign w_xfer      = r_out_valid & out_ready;
  assign w_conv_last = (r_state == S_CONV) && (r_cnt == CW'(WIDTH - 1));

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;

  // One double-dabble step: add 3 to nibbles >= 5, then shift in the next MSB.
  always_comb begin
    w_bcd_adj = r_bcd;
    for (int i = 0; i < NDIG; i++) begin
      if (r_bcd[i*4 +: 4] >= 4'd5) w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
    end
    w_bcd_shift = {w_bcd_adj[BW-2:0], r_shift[WIDTH-1]};
  end

  // Highest non-zero digit of the finished conversion; stays 0 for value 0 so the
  // units digit is printed.
  always_comb begin
    w_first_idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (w_bcd_shift[i*4 +: 4] != 4'd0) w_first_idx = IW'(i);
    end
  end

  assign w_first_digit = f_nibble(w_bcd_shift, w_first_idx);
  assign w_next_digit  = f_nibble(r_bcd, r_dig_idx - 1'b1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)                     w_state_next = S_CONV;
      S_CONV:  if (w_conv_last)                  w_state_next = S_SEND;
      S_SEND:  if (w_xfer && (r_dig_idx == '0))  w_state_next = S_EOLS;
      S_EOLS:  if (w_xfer)                       w_state_next = S_IDLE;
      default:                                   w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_bcd       <= '0;
      r_cnt       <= '0;
      r_dig_idx   <= '0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift <= in_value;
            r_bcd   <= '0;
            r_cnt   <= '0;
          end
        end
        S_CONV: begin
          r_shift <= r_shift << 1;
          r_bcd   <= w_bcd_shift;
          r_cnt   <= r_cnt + 1'b1;
          if (w_conv_last) begin
            r_dig_idx   <= w_first_idx;
            r_out_data  <= 8'h30 + {4'h0, w_first_digit};
            r_out_valid <= 1'b1;
          end
        end
        S_SEND: begin
          // Next character is loaded on the same edge as the transfer: no bubble.
          if (w_xfer) begin
            if (r_dig_idx == '0) begin
              r_out_data <= EOL;
            end else begin
              r_dig_idx  <= r_dig_idx - 1'b1;
              r_out_data <= 8'h30 + {4'h0, w_next_digit};
            end
          end
        end
        S_EOLS: begin
          if (w_xfer) begin
            r_out_valid <= 1'b0;
            r_out_data  <= 8'h00;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_ascii_tx.sv
// tb/tb_sum_ascii_tx.sv - self-checking bench for sum_ascii_tx (WIDTH 6 and 10)

module tb_sum_ascii_tx;

  logic       clk;
  logic       rst_n;

  logic       in_valid6, in_ready6, out_valid6, out_ready6, busy6;
  logic [5:0] in_value6;
  logic [7:0] out_data6;

  logic       in_valid10, in_ready10, out_valid10, out_ready10, busy10;
  logic [9:0] in_value10;
  logic [7:0] out_data10;

  int total = 0;
  int bad   = 0;
  longint cycles = 0;

  sum_ascii_tx #(.WIDTH(6), .EOL(8'h0A)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_value(in_value6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6),
    .busy(busy6)
  );

  sum_ascii_tx #(.WIDTH(10), .EOL(8'h0A)) dut10 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid10), .in_ready(in_ready10), .in_value(in_value10),
    .out_valid(out_valid10), .out_ready(out_ready10), .out_data(out_data10),
    .busy(busy10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycles++;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int get_ov(input int sel);
    return sel ? int'(out_valid10) : int'(out_valid6);
  endfunction
  function automatic int get_od(input int sel);
    return sel ? int'(out_data10) : int'(out_data6);
  endfunction
  function automatic int get_ir(input int sel);
    return sel ? int'(in_ready10) : int'(in_ready6);
  endfunction
  function automatic int get_busy(input int sel);
    return sel ? int'(busy10) : int'(busy6);
  endfunction

  task automatic set_in(input int sel, input bit v, input int value);
    if (sel) begin in_valid10 = v; in_value10 = value[9:0]; end
    else     begin in_valid6  = v; in_value6  = value[5:0]; end
  endtask

  task automatic set_rdy(input int sel, input bit r);
    if (sel) out_ready10 = r;
    else     out_ready6  = r;
  endtask

  // Called and returns at a negedge. mode: 0 ready always, 1 toggle, 2 random.
  // hold9 keeps in_valid high with value 9 for the whole line.
  task automatic transact(input int sel, input int value, input int mode,
                          input bit hold9, output longint acc_cyc);
    int     q[$];
    int     v, w, cyc, n, guard;
    bit     rdy, stalled;
    int     held;
    w = sel ? 10 : 6;
    v = value;
    do begin
      q.push_front(48 + (v % 10));
      v = v / 10;
    end while (v != 0);
    q.push_back(10);

    chk("in_ready_idle", get_ir(sel), 1);
    chk("busy_idle", get_busy(sel), 0);
    set_in(sel, 1'b1, value);
    @(negedge clk);
    acc_cyc = cycles;
    if (hold9) set_in(sel, 1'b1, 9);
    else       set_in(sel, 1'b0, 0);

    cyc = 0;
    while (get_ov(sel) == 0 && cyc < 40) begin
      chk("busy_conv", get_busy(sel), 1);
      chk("in_ready_conv", get_ir(sel), 0);
      @(negedge clk);
      cyc++;
    end
    chk("first_valid_latency", cyc, w);

    n = 0; guard = 0; stalled = 1'b0; held = 0;
    while (n < q.size() && guard < 200) begin
      chk("valid_in_line", get_ov(sel), 1);
      if (stalled) chk("stall_data", get_od(sel), held);
      chk("in_ready_busy", get_ir(sel), 0);
      chk("busy_line", get_busy(sel), 1);
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (guard % 2) == 0;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      set_rdy(sel, rdy);
      if (get_ov(sel) != 0 && rdy) begin
        chk("byte", get_od(sel), q[n]);
        n++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = get_od(sel);
      end
      @(negedge clk);
      guard++;
    end
    chk("transfers", n, q.size());
    set_rdy(sel, 1'b0);
    set_in(sel, 1'b0, 0);
    chk("valid_after_eol", get_ov(sel), 0);
    chk("busy_after_eol", get_busy(sel), 0);
    chk("in_ready_after_eol", get_ir(sel), 1);
  endtask

  initial begin
    longint a1, a2;
    int     g;
    rst_n = 1'b0;
    set_in(0, 1'b0, 0); set_in(1, 1'b0, 0);
    set_rdy(0, 1'b0);   set_rdy(1, 1'b0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("rst_valid", get_ov(s), 0);
      chk("rst_data", get_od(s), 0);
      chk("rst_busy", get_busy(s), 0);
      chk("rst_in_ready", get_ir(s), 1);
    end
    rst_n = 1'b1;
    @(negedge clk);

    // T1..T4 on the 6-bit instance
    transact(0, 0,  0, 1'b0, a1);
    transact(0, 45, 0, 1'b0, a1);
    transact(0, 62, 1, 1'b0, a1);
    transact(0, 7,  0, 1'b1, a1);
    transact(0, 63, 1, 1'b0, a1);
    transact(0, 10, 2, 1'b0, a1);

    // T5: reset while the first digit of 30 is waiting
    set_in(0, 1'b1, 30);
    @(negedge clk);
    set_in(0, 1'b0, 0);
    g = 0;
    while (get_ov(0) == 0 && g < 40) begin @(negedge clk); g++; end
    chk("t5_first_digit", get_od(0), 8'h33);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_async_valid", get_ov(0), 0);
    chk("t5_async_busy", get_busy(0), 0);
    chk("t5_async_data", get_od(0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_idle_valid", get_ov(0), 0);
    transact(0, 5, 0, 1'b0, a1);

    // T6: 10-bit instance, back-to-back, maximum value first
    transact(1, 1023, 0, 1'b0, a1);
    transact(1, 1000, 0, 1'b0, a2);
    chk("t6_throughput", int'(a2 - a1), 1 + 10 + 4 + 1);
    transact(1, 0, 1, 1'b0, a1);

    // Randomized lines on both instances
    for (int i = 0; i < 8; i++) transact(0, int'($urandom_range(0, 63)), 2, 1'b0, a1);
    for (int i = 0; i < 6; i++) transact(1, int'($urandom_range(0, 1023)), 2, 1'b0, a1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
